// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Defaults describe 640x480@60 with the standard porches.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int act, input int fp);
        return act + fp;
    endfunction

    localparam int DEF_H_TOT      = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOT      = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_HS_START   = sync_start(DEF_H_ACTIVE, DEF_H_FP);
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START   = sync_start(DEF_V_ACTIVE, DEF_V_FP);
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that carries raw sync/blank alongside the
// pixel fetch latency; resets to the idle pattern given by RST_VAL.
module vga_delay_line #(
    parameter int            DEPTH   = 3,
    parameter int            W       = 3,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= {DEPTH{RST_VAL}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: raster counters, frame-boundary enable, pixel
// requests upstream and sync/blank realigned with the returned pixel data.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_LAT  = 2,
    parameter int PIX_W    = 24
) (
    input  logic                          vga_CLK,
    input  logic                          vga_RST,
    input  logic                          vga_EN,
    output logic                          vga_REQ,
    output logic [$clog2(H_ACTIVE)-1:0]   vga_X,
    output logic [$clog2(V_ACTIVE)-1:0]   vga_Y,
    output logic                          vga_SOF,
    input  logic [PIX_W-1:0]              vga_PIX_IN,
    output logic                          vga_HS,
    output logic                          vga_VS,
    output logic                          vga_BLANK,
    output logic [PIX_W-1:0]              vga_RGB
);

    localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = $clog2(V_ACTIVE);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [HW-1:0] H_SE_C   = HW'(sync_start(H_ACTIVE, H_FP) + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [VW-1:0] V_SE_C   = VW'(sync_start(V_ACTIVE, V_FP) + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOT - 1);

    // Idle pattern for {hs, vs, blank}: syncs inactive, blanked.
    localparam logic [2:0] RAW_IDLE = {~HS_POL, ~VS_POL, 1'b1};

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          running_q, running_d;
    logic          req_q, req_d;
    logic          sof_q, sof_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic          h_wrap, eof, active;
    logic          hs_in_sync, vs_in_sync;
    logic [2:0]    raw_sig, dly_sig;

    assign h_wrap = (h_cnt_q == H_LAST_C);
    assign eof    = h_wrap && (v_cnt_q == V_LAST_C);
    assign active = running_q && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);

    // The enable only matters in idle or at the last clock of a frame.
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        running_d = running_q;
        if (running_q) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) begin
                v_cnt_d = eof ? '0 : v_cnt_q + 1'b1;
            end
            if (eof) begin
                running_d = vga_EN;
            end
        end else begin
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            running_d = vga_EN;
        end
    end

    always_comb begin
        req_d = active;
        sof_d = active && (h_cnt_q == '0) && (v_cnt_q == '0);
        x_d   = active ? h_cnt_q[XW-1:0] : x_q;
        y_d   = active ? v_cnt_q[YW-1:0] : y_q;
    end

    always_ff @(posedge vga_CLK or posedge vga_RST) begin
        if (vga_RST) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            running_q <= 1'b0;
            req_q     <= 1'b0;
            sof_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            running_q <= running_d;
            req_q     <= req_d;
            sof_q     <= sof_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    // Raw sync/blank are taken straight from the counters, so the line needs
    // one extra stage to match the registered request plus PIX_LAT.
    always_comb begin
        hs_in_sync = running_q && (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
        vs_in_sync = running_q && (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);
        raw_sig    = {hs_in_sync ? HS_POL : ~HS_POL,
                      vs_in_sync ? VS_POL : ~VS_POL,
                      ~active};
    end

    vga_delay_line #(
        .DEPTH   (PIX_LAT + 1),
        .W       (3),
        .RST_VAL (RAW_IDLE)
    ) u_dly (
        .clk  (vga_CLK),
        .rst  (vga_RST),
        .din  (raw_sig),
        .dout (dly_sig)
    );

    assign vga_REQ   = req_q;
    assign vga_SOF   = sof_q;
    assign vga_X     = x_q;
    assign vga_Y     = y_q;
    assign vga_HS    = dly_sig[2];
    assign vga_VS    = dly_sig[1];
    assign vga_BLANK = dly_sig[0];
    assign vga_RGB   = dly_sig[0] ? '0 : vga_PIX_IN;

endmodule
